// File: rtl/sensor_monitor_ctrl.sv
// Periodic sensor sampler with an error rule, multi-sample fault confirmation,
// a latched alarm with acknowledge, and a saturating count of alarm entries.
module sensor_monitor_ctrl #(
  parameter int unsigned SAMPLE_PERIOD = 4,
  parameter int unsigned CONFIRM_COUNT = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  input  logic [3:0] sensors,
  input  logic       alarm_ack,
  output logic       sample_tick,
  output logic       error_raw,
  output logic       alarm,
  output logic [3:0] alarm_code,
  output logic [7:0] fault_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    CONFIRM = 2'd2,
    ALARM   = 2'd3
  } state_t;

  localparam logic [15:0] PERIOD_LAST    = 16'(SAMPLE_PERIOD - 1);
  localparam logic [3:0]  CONFIRM_TARGET = 4'(CONFIRM_COUNT);

  function automatic logic error_rule(input logic [3:0] s);
    return s[0] | (s[1] & (s[2] | s[3]));
  endfunction

  state_t      state_r, state_s;
  logic [15:0] period_cnt_r;
  logic [3:0]  confirm_r, confirm_s;
  logic [3:0]  sample_r;
  logic        tick_r;
  logic [3:0]  code_r;
  logic [7:0]  faults_r;
  logic        wrap_s;
  logic        error_s;
  logic        enter_alarm_s;

  assign wrap_s  = enable && (period_cnt_r == PERIOD_LAST);
  assign error_s = error_rule(sample_r);

  // Period counter, sample capture and the one-cycle tick at each wrap.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      period_cnt_r <= 16'd0;
      sample_r     <= 4'd0;
      tick_r       <= 1'b0;
    end else if (!enable) begin
      period_cnt_r <= 16'd0;
      tick_r       <= 1'b0;
    end else if (wrap_s) begin
      period_cnt_r <= 16'd0;
      sample_r     <= sensors;
      tick_r       <= 1'b1;
    end else begin
      period_cnt_r <= period_cnt_r + 16'd1;
      tick_r       <= 1'b0;
    end
  end

  // State and confirmation counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= IDLE;
      confirm_r <= 4'd0;
    end else begin
      state_r   <= state_s;
      confirm_r <= confirm_s;
    end
  end

  // Next-state logic; the acknowledge takes priority over a coincident tick in ALARM.
  always_comb begin
    state_s       = state_r;
    confirm_s     = confirm_r;
    enter_alarm_s = 1'b0;
    if (!enable) begin
      state_s   = IDLE;
      confirm_s = 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s   = MONITOR;
          confirm_s = 4'd0;
        end
        MONITOR: begin
          if (tick_r && error_s) begin
            confirm_s = 4'd1;
            if (CONFIRM_TARGET == 4'd1) begin
              state_s       = ALARM;
              enter_alarm_s = 1'b1;
            end else begin
              state_s = CONFIRM;
            end
          end else begin
            state_s = MONITOR;
          end
        end
        CONFIRM: begin
          if (tick_r && error_s) begin
            confirm_s = confirm_r + 4'd1;
            if (confirm_s >= CONFIRM_TARGET) begin
              state_s       = ALARM;
              enter_alarm_s = 1'b1;
            end else begin
              state_s = CONFIRM;
            end
          end else if (tick_r) begin
            confirm_s = 4'd0;
            state_s   = MONITOR;
          end else begin
            state_s = CONFIRM;
          end
        end
        ALARM: begin
          if (alarm_ack) begin
            state_s   = MONITOR;
            confirm_s = 4'd0;
          end else begin
            state_s = ALARM;
          end
        end
        default: begin
          state_s   = IDLE;
          confirm_s = 4'd0;
        end
      endcase
    end
  end

  // Alarm code and saturating fault counter update only on alarm entry.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      code_r   <= 4'd0;
      faults_r <= 8'd0;
    end else if (enter_alarm_s) begin
      code_r   <= sample_r;
      faults_r <= (faults_r == 8'd255) ? 8'd255 : faults_r + 8'd1;
    end else begin
      code_r   <= code_r;
      faults_r <= faults_r;
    end
  end

  assign sample_tick = tick_r;
  assign error_raw   = error_s;
  assign alarm       = (state_r == ALARM);
  assign alarm_code  = code_r;
  assign fault_count = faults_r;

endmodule

// File: doc/sensor_monitor_ctrl.md
SENSOR_MONITOR_CTRL -- requirements
Module: sensor_monitor_ctrl

Interface
REQ-001 Parameter: SAMPLE_PERIOD, 4, clock cycles between sensor samples; legal range 2..65535.
REQ-002 Parameter: CONFIRM_COUNT, 3, consecutive erroneous samples required to raise an alarm; legal range 1..15.
REQ-003 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: n_rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: enable  input  1  monitoring enable; low forces IDLE.
REQ-006 Port: sensors  input  4  raw sensor bus.
REQ-007 Port: alarm_ack  input  1  one-cycle acknowledge that clears an active alarm.
REQ-008 Port: sample_tick  output  1  one-cycle pulse; a new sample is held in the sample register this cycle.
REQ-009 Port: error_raw  output  1  error rule applied to the sample register.
REQ-010 Port: alarm  output  1  confirmed-fault flag, level.
REQ-011 Port: alarm_code  output  4  sample value that completed confirmation.
REQ-012 Port: fault_count  output  8  number of alarm entries since reset, saturating.

Function
REQ-013 Error rule: error_raw = s[0] | (s[1] & (s[2] | s[3])), where s is the registered sample.
REQ-014 Period counter: while enable=1, counts 0..SAMPLE_PERIOD-1 and then wraps to 0.
REQ-015 At wrap, on the same clock edge: the sample register loads sensors and sample_tick is registered high for exactly one cycle.
REQ-016 With enable continuously high, the first sample_tick occurs SAMPLE_PERIOD cycles after the first enabled cycle; later ticks follow every SAMPLE_PERIOD cycles.
REQ-017 FSM states: IDLE, MONITOR, CONFIRM, ALARM.
REQ-018 Transition IDLE -> MONITOR: on the first edge with enable=1.
REQ-019 Transition MONITOR, on sample_tick with error_raw=1: confirm count becomes 1; next state is ALARM if CONFIRM_COUNT=1, otherwise CONFIRM.
REQ-020 Transition CONFIRM, on sample_tick with error_raw=1: confirm count increments; on reaching CONFIRM_COUNT, next state is ALARM.
REQ-021 Transition CONFIRM, on sample_tick with error_raw=0: confirm count clears to 0; next state is MONITOR.
REQ-022 Cycles without sample_tick do not change the confirm count or the state (except by enable or alarm_ack).
REQ-023 Entering ALARM: alarm=1 from the cycle after the confirming tick; alarm_code latches the confirming sample; fault_count increments, saturating at 255.
REQ-024 In ALARM, sampling continues; alarm_code and fault_count hold; further erroneous ticks do not increment fault_count.
REQ-025 Transition ALARM, on alarm_ack=1: next state is MONITOR; confirm count clears; alarm=0 from the next cycle.
REQ-026 alarm_ack coincident with sample_tick in ALARM: the acknowledge wins; that sample is discarded and not counted toward confirmation.
REQ-027 alarm_ack in any state other than ALARM: ignored.
REQ-028 enable=0 in any state: next state is IDLE; period counter and confirm count clear; alarm=0 and sample_tick=0 from the next cycle.
REQ-029 While enable=0: alarm_code, fault_count and the sample register hold their values.
REQ-030 All outputs are registered or are decoded directly from registers; no combinational path from inputs to outputs.

Reset
REQ-031 While n_rst=0, the following are immediately and asynchronously forced, independent of clk: state=IDLE; counters=0; sample register=0; sample_tick=0; alarm=0; alarm_code=4'b0000; fault_count=0; error_raw=0.
REQ-032 Reset asserted mid-CONFIRM or mid-ALARM discards all progress; after release, operation restarts per REQ-016.

Verification (SAMPLE_PERIOD=4, CONFIRM_COUNT=3, enable=1)
REQ-033 sensors=4'b0000 for 40 cycles -> sample_tick every 4th cycle; error_raw=0, alarm=0, fault_count=0 throughout.
REQ-034 sensors=4'b0001 held -> alarm=1 one cycle after the 3rd tick; alarm_code=4'b0001; fault_count=1; fault_count still 1 after 5 more ticks.
REQ-035 sensors=4'b0110 for 2 ticks, then 4'b0000 for 1 tick, then 4'b1010 for 3 ticks -> no alarm during the first sequence; alarm after the 3rd 4'b1010 tick with alarm_code=4'b1010.
REQ-036 sensors=4'b1100 held 10 ticks -> error_raw=0 and alarm=0 (s[1]=0).
REQ-037 In ALARM with sensors=4'b0001, alarm_ack pulsed on the same cycle as sample_tick -> alarm=0 next cycle; alarm re-asserts only after 3 further ticks; fault_count=2.
REQ-038 n_rst pulled low 2 cycles into CONFIRM, mid-cycle -> all outputs 0 before the next clk edge; after release, the first tick occurs 4 cycles later.
